// File: rtl/evm_booth_arbiter_if.sv
// Booth front-end and tally signals of the shared vote arbiter.
// The master side drives the i_* inputs; the slave side is the arbiter.
interface evm_booth_arbiter_if #(
   parameter int unsigned NUM_BOOTHS = 3,
   parameter int unsigned WIDTH      = 7
);
   logic                    i_session_open;
   logic                    i_clear_counts;
   logic [NUM_BOOTHS-1:0]   i_booth_enable;
   logic [NUM_BOOTHS-1:0]   i_booth_vote_valid;
   logic [2*NUM_BOOTHS-1:0] i_booth_vote_sel;
   logic [NUM_BOOTHS-1:0]   o_booth_armed;
   logic [NUM_BOOTHS-1:0]   o_booth_ack;
   logic [NUM_BOOTHS-1:0]   o_booth_reject;
   logic [NUM_BOOTHS-1:0]   o_booth_timeout;
   logic [WIDTH-1:0]        o_count_1;
   logic [WIDTH-1:0]        o_count_2;
   logic [WIDTH-1:0]        o_count_3;
   logic [WIDTH-1:0]        o_total_votes;
   logic                    o_overflow;
   logic [1:0]              o_session_state;

   modport master (
      output i_session_open, i_clear_counts, i_booth_enable, i_booth_vote_valid,
             i_booth_vote_sel,
      input  o_booth_armed, o_booth_ack, o_booth_reject, o_booth_timeout, o_count_1,
             o_count_2, o_count_3, o_total_votes, o_overflow, o_session_state
   );

   modport slave (
      input  i_session_open, i_clear_counts, i_booth_enable, i_booth_vote_valid,
             i_booth_vote_sel,
      output o_booth_armed, o_booth_ack, o_booth_reject, o_booth_timeout, o_count_1,
             o_count_2, o_count_3, o_total_votes, o_overflow, o_session_state
   );
endinterface

// File: rtl/evm_booth_arbiter.sv
// Voting-booth controller: arms booths for one vote each and serialises captured
// votes round-robin into saturating per-candidate tallies.
module evm_booth_arbiter #(
   parameter int unsigned NUM_BOOTHS = 3,
   parameter int unsigned WIDTH      = 7,
   parameter int unsigned TIMEOUT    = 200
) (
   input logic                clk,
   input logic                rst_n,
   evm_booth_arbiter_if.slave bus
);
   localparam int unsigned      PtrW     = (NUM_BOOTHS > 1) ? $clog2(NUM_BOOTHS) : 1;
   localparam logic [WIDTH-1:0] CntMax   = '1;
   localparam logic [15:0]      IdleLast = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      StClosed   = 2'b00,
      StOpen     = 2'b01,
      StDraining = 2'b10
   } state_e;

   state_e                r_state;
   logic [NUM_BOOTHS-1:0] r_armed;
   logic [NUM_BOOTHS-1:0] r_pending;
   logic [NUM_BOOTHS-1:0] r_ack;
   logic [NUM_BOOTHS-1:0] r_reject;
   logic [NUM_BOOTHS-1:0] r_timeout;
   logic [1:0]            r_code [NUM_BOOTHS];
   logic [15:0]           r_idle [NUM_BOOTHS];
   logic [PtrW-1:0]       r_ptr;
   logic [WIDTH-1:0]      r_count_1;
   logic [WIDTH-1:0]      r_count_2;
   logic [WIDTH-1:0]      r_count_3;
   logic [WIDTH-1:0]      r_total;
   logic                  r_overflow;

   logic [1:0]            w_sel [NUM_BOOTHS];
   logic [NUM_BOOTHS-1:0] w_capture;
   logic [NUM_BOOTHS-1:0] w_expire;
   logic [NUM_BOOTHS-1:0] w_arm;
   logic [NUM_BOOTHS-1:0] w_rej;
   logic [NUM_BOOTHS-1:0] w_gnt_vec;
   logic                  w_gnt_vld;
   logic [PtrW-1:0]       w_gnt_idx;
   logic [1:0]            w_gnt_code;
   logic                  w_drain_entry;

   function automatic logic [PtrW-1:0] rr_idx(input logic [PtrW-1:0] p, input int unsigned k);
      int unsigned s;
      s = (32'(p) + k) % NUM_BOOTHS;
      return s[PtrW-1:0];
   endfunction

   // First pending booth at or after the pointer, wrapping.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      for (int unsigned k = 0; k < NUM_BOOTHS; k++) begin
         if (!w_gnt_vld && r_pending[rr_idx(r_ptr, k)]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = rr_idx(r_ptr, k);
         end
      end
      w_gnt_code = r_code[w_gnt_idx];
   end

   always_comb begin
      w_drain_entry = (r_state == StOpen) && !bus.i_session_open;
      w_capture     = '0;
      w_expire      = '0;
      w_arm         = '0;
      w_rej         = '0;
      w_gnt_vec     = '0;
      for (int unsigned i = 0; i < NUM_BOOTHS; i++) begin
         w_sel[i]     = bus.i_booth_vote_sel[2*i +: 2];
         w_gnt_vec[i] = w_gnt_vld && (w_gnt_idx == PtrW'(i));
         w_capture[i] = r_armed[i] && bus.i_booth_vote_valid[i] && (w_sel[i] != 2'b00);
         w_expire[i]  = r_armed[i] && (r_idle[i] == IdleLast) && !w_capture[i];
         w_arm[i]     = (r_state == StOpen) && bus.i_booth_enable[i] && !r_armed[i] &&
                        !r_pending[i];
         // Timeout beats a bad code; an ack beats a resubmission while pending.
         w_rej[i]     = bus.i_booth_vote_valid[i] &&
                        ((r_armed[i] && (w_sel[i] == 2'b00) && !w_expire[i]) ||
                         (r_pending[i] && !w_gnt_vec[i]));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= StClosed;
         r_armed    <= '0;
         r_pending  <= '0;
         r_ack      <= '0;
         r_reject   <= '0;
         r_timeout  <= '0;
         r_ptr      <= '0;
         r_count_1  <= '0;
         r_count_2  <= '0;
         r_count_3  <= '0;
         r_total    <= '0;
         r_overflow <= 1'b0;
         for (int unsigned i = 0; i < NUM_BOOTHS; i++) begin
            r_code[i] <= '0;
            r_idle[i] <= '0;
         end
      end else begin
         case (r_state)
            StClosed:   if (bus.i_session_open) r_state <= StOpen;
            StOpen:     if (!bus.i_session_open) r_state <= StDraining;
            StDraining: begin
               if (bus.i_session_open) r_state <= StOpen;
               else if (r_pending == '0) r_state <= StClosed;
            end
            default:    r_state <= StClosed;
         endcase

         r_ack     <= w_gnt_vec;
         r_reject  <= w_rej;
         r_timeout <= w_expire;

         for (int unsigned i = 0; i < NUM_BOOTHS; i++) begin
            if (w_drain_entry) r_armed[i] <= 1'b0;
            else if (w_arm[i]) r_armed[i] <= 1'b1;
            else if (w_capture[i] || w_expire[i]) r_armed[i] <= 1'b0;

            if (w_arm[i]) r_idle[i] <= '0;
            else if (r_armed[i]) r_idle[i] <= r_idle[i] + 16'd1;

            if (w_capture[i]) begin
               r_pending[i] <= 1'b1;
               r_code[i]    <= w_sel[i];
            end else if (w_gnt_vec[i]) begin
               r_pending[i] <= 1'b0;
            end
         end

         if (w_gnt_vld) begin
            r_ptr <= (w_gnt_idx == PtrW'(NUM_BOOTHS - 1)) ? '0 : w_gnt_idx + 1'b1;
         end

         if ((r_state == StClosed) && bus.i_clear_counts) begin
            r_count_1  <= '0;
            r_count_2  <= '0;
            r_count_3  <= '0;
            r_total    <= '0;
            r_overflow <= 1'b0;
         end else if (w_gnt_vld) begin
            case (w_gnt_code)
               2'b01: if (r_count_1 == CntMax) r_overflow <= 1'b1;
                      else r_count_1 <= r_count_1 + 1'b1;
               2'b10: if (r_count_2 == CntMax) r_overflow <= 1'b1;
                      else r_count_2 <= r_count_2 + 1'b1;
               2'b11: if (r_count_3 == CntMax) r_overflow <= 1'b1;
                      else r_count_3 <= r_count_3 + 1'b1;
               default: ;
            endcase
            if (r_total == CntMax) r_overflow <= 1'b1;
            else r_total <= r_total + 1'b1;
         end
      end
   end

   assign bus.o_booth_armed   = r_armed;
   assign bus.o_booth_ack     = r_ack;
   assign bus.o_booth_reject  = r_reject;
   assign bus.o_booth_timeout = r_timeout;
   assign bus.o_count_1       = r_count_1;
   assign bus.o_count_2       = r_count_2;
   assign bus.o_count_3       = r_count_3;
   assign bus.o_total_votes   = r_total;
   assign bus.o_overflow      = r_overflow;
   assign bus.o_session_state = r_state;

endmodule

// File: tb/tb_evm_booth_arbiter.sv
// Directed bench for evm_booth_arbiter with 3 booths, 3-bit counters and a
// 4-cycle idle timeout; inputs change 1 ns after each rising edge.
module tb_evm_booth_arbiter;
   localparam int unsigned NB = 3;
   localparam int unsigned W  = 3;
   localparam int unsigned TO = 4;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   evm_booth_arbiter_if #(.NUM_BOOTHS(NB), .WIDTH(W)) bus ();

   evm_booth_arbiter #(
      .NUM_BOOTHS(NB),
      .WIDTH     (W),
      .TIMEOUT   (TO)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks                = 0;
      n_errors                = 0;
      rst_n                   = 1'b0;
      bus.i_session_open      = 1'b0;
      bus.i_clear_counts      = 1'b0;
      bus.i_booth_enable      = '0;
      bus.i_booth_vote_valid  = '0;
      bus.i_booth_vote_sel    = '0;
      #3;
      chk("rst_state", 32'(bus.o_session_state), 32'd0);
      chk("rst_armed", 32'(bus.o_booth_armed), 32'd0);
      chk("rst_total", 32'(bus.o_total_votes), 32'd0);
      chk("rst_ovf", 32'(bus.o_overflow), 32'd0);
      tick();
      rst_n = 1'b1;

      // Single vote, booth 0, candidate 1.
      bus.i_session_open = 1'b1;
      tick();
      chk("t1_open", 32'(bus.o_session_state), 32'd1);
      bus.i_booth_enable = 3'b001;
      tick();
      bus.i_booth_enable = '0;
      chk("t1_armed", 32'(bus.o_booth_armed), 32'b001);
      bus.i_booth_vote_valid = 3'b001;
      bus.i_booth_vote_sel   = 6'b00_00_01;
      tick();
      bus.i_booth_vote_valid = '0;
      chk("t1_ack_t1", 32'(bus.o_booth_ack), 32'b000);
      chk("t1_disarm", 32'(bus.o_booth_armed), 32'b000);
      tick();
      chk("t1_ack_t2", 32'(bus.o_booth_ack), 32'b001);
      chk("t1_cnt1", 32'(bus.o_count_1), 32'd1);
      chk("t1_total", 32'(bus.o_total_votes), 32'd1);
      tick();
      chk("t1_ack_off", 32'(bus.o_booth_ack), 32'b000);

      // Three simultaneous votes with the pointer back at booth 0.
      do_reset();
      chk("t2_rst_cnt1", 32'(bus.o_count_1), 32'd0);
      tick();
      bus.i_booth_enable = 3'b111;
      tick();
      bus.i_booth_enable = '0;
      chk("t2_armed", 32'(bus.o_booth_armed), 32'b111);
      bus.i_booth_vote_valid = 3'b111;
      bus.i_booth_vote_sel   = 6'b11_10_01;
      tick();
      bus.i_booth_vote_valid = '0;
      chk("t2_ack_none", 32'(bus.o_booth_ack), 32'b000);
      tick();
      chk("t2_ack0", 32'(bus.o_booth_ack), 32'b001);
      tick();
      chk("t2_ack1", 32'(bus.o_booth_ack), 32'b010);
      tick();
      chk("t2_ack2", 32'(bus.o_booth_ack), 32'b100);
      tick();
      chk("t2_ack_off", 32'(bus.o_booth_ack), 32'b000);
      chk("t2_cnt1", 32'(bus.o_count_1), 32'd1);
      chk("t2_cnt2", 32'(bus.o_count_2), 32'd1);
      chk("t2_cnt3", 32'(bus.o_count_3), 32'd1);
      chk("t2_total", 32'(bus.o_total_votes), 32'd3);

      // Invalid code then a good one on booth 1 (pointer now at booth 0).
      bus.i_booth_enable = 3'b010;
      tick();
      bus.i_booth_enable     = '0;
      bus.i_booth_vote_valid = 3'b010;
      bus.i_booth_vote_sel   = 6'b00_00_00;
      tick();
      chk("t3_reject", 32'(bus.o_booth_reject), 32'b010);
      chk("t3_still_armed", 32'(bus.o_booth_armed), 32'b010);
      bus.i_booth_vote_sel = 6'b00_10_00;
      tick();
      bus.i_booth_vote_valid = '0;
      chk("t3_rej_off", 32'(bus.o_booth_reject), 32'b000);
      tick();
      chk("t3_ack", 32'(bus.o_booth_ack), 32'b010);
      chk("t3_cnt2", 32'(bus.o_count_2), 32'd2);
      chk("t3_total", 32'(bus.o_total_votes), 32'd4);

      // Idle timeout on booth 2.
      bus.i_booth_enable = 3'b100;
      tick();
      bus.i_booth_enable = '0;
      chk("t4_armed", 32'(bus.o_booth_armed), 32'b100);
      tick();
      tick();
      tick();
      chk("t4_pre_to", 32'(bus.o_booth_timeout), 32'b000);
      chk("t4_pre_armed", 32'(bus.o_booth_armed), 32'b100);
      tick();
      chk("t4_timeout", 32'(bus.o_booth_timeout), 32'b100);
      chk("t4_disarmed", 32'(bus.o_booth_armed), 32'b000);
      bus.i_booth_vote_valid = 3'b100;
      bus.i_booth_vote_sel   = 6'b01_00_00;
      tick();
      bus.i_booth_vote_valid = '0;
      chk("t4_to_off", 32'(bus.o_booth_timeout), 32'b000);
      chk("t4_no_rej", 32'(bus.o_booth_reject), 32'b000);
      tick();
      chk("t4_no_ack", 32'(bus.o_booth_ack), 32'b000);
      chk("t4_total", 32'(bus.o_total_votes), 32'd4);

      // Two pending votes drained after the session closes (pointer at booth 2).
      bus.i_booth_enable = 3'b011;
      tick();
      bus.i_booth_enable     = '0;
      bus.i_booth_vote_valid = 3'b011;
      bus.i_booth_vote_sel   = 6'b00_11_11;
      tick();
      bus.i_booth_vote_valid = '0;
      bus.i_session_open     = 1'b0;
      tick();
      chk("t6_draining", 32'(bus.o_session_state), 32'd2);
      chk("t6_ack0", 32'(bus.o_booth_ack), 32'b001);
      tick();
      chk("t6_ack1", 32'(bus.o_booth_ack), 32'b010);
      chk("t6_still_drain", 32'(bus.o_session_state), 32'd2);
      tick();
      chk("t6_closed", 32'(bus.o_session_state), 32'd0);
      chk("t6_cnt3", 32'(bus.o_count_3), 32'd3);
      chk("t6_total", 32'(bus.o_total_votes), 32'd6);
      bus.i_clear_counts = 1'b1;
      tick();
      bus.i_clear_counts = 1'b0;
      chk("t6_clr_cnt2", 32'(bus.o_count_2), 32'd0);
      chk("t6_clr_cnt3", 32'(bus.o_count_3), 32'd0);
      chk("t6_clr_total", 32'(bus.o_total_votes), 32'd0);

      // Eight votes for candidate 3 against 3-bit counters.
      bus.i_session_open = 1'b1;
      tick();
      for (int v = 0; v < 8; v++) begin
         bus.i_booth_enable = 3'b001;
         tick();
         bus.i_booth_enable     = '0;
         bus.i_booth_vote_valid = 3'b001;
         bus.i_booth_vote_sel   = 6'b00_00_11;
         tick();
         bus.i_booth_vote_valid = '0;
         tick();
         chk("t5_ack", 32'(bus.o_booth_ack), 32'b001);
         chk("t5_cnt3", 32'(bus.o_count_3), (v < 7) ? 32'(v + 1) : 32'd7);
      end
      chk("t5_total", 32'(bus.o_total_votes), 32'd7);
      chk("t5_ovf", 32'(bus.o_overflow), 32'd1);

      // clear_counts has no effect while OPEN, then works once CLOSED.
      bus.i_clear_counts = 1'b1;
      tick();
      bus.i_clear_counts = 1'b0;
      chk("t7_open_cnt3", 32'(bus.o_count_3), 32'd7);
      chk("t7_open_ovf", 32'(bus.o_overflow), 32'd1);
      bus.i_session_open = 1'b0;
      tick();
      tick();
      chk("t7_closed", 32'(bus.o_session_state), 32'd0);
      bus.i_clear_counts = 1'b1;
      tick();
      bus.i_clear_counts = 1'b0;
      chk("t7_clr_cnt3", 32'(bus.o_count_3), 32'd0);
      chk("t7_clr_ovf", 32'(bus.o_overflow), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/evm_booth_arbiter.md
Name: evm_booth_arbiter

Overview:
- Controller that lets NUM_BOOTHS voting booths share one vote tally.
- The presiding officer arms each booth for exactly one vote. Armed booths submit a candidate code.
- A round-robin arbiter serialises pending votes into the shared per-candidate counters, one vote per cycle.
- Sits between the booth push-button front ends and the results/display logic.

Parameters:
NUM_BOOTHS, 3, number of requesting booths (2..8)
WIDTH, 7, width of each candidate counter and of total_votes
TIMEOUT, 200, cycles an armed booth may stay idle before it is disarmed (1..65535)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
session_open  input  1  level; high = polling session active
clear_counts  input  1  pulse; zero all counters, honoured only in CLOSED
booth_enable  input  NUM_BOOTHS  per-booth pulse from officer; arms that booth
booth_vote_valid  input  NUM_BOOTHS  per-booth vote strobe
booth_vote_sel  input  2*NUM_BOOTHS  per-booth candidate code, booth i on bits [2i+1:2i]; 01/10/11 = candidate 1/2/3, 00 = invalid
booth_armed  output  NUM_BOOTHS  booth may vote
booth_ack  output  NUM_BOOTHS  1-cycle pulse; vote counted
booth_reject  output  NUM_BOOTHS  1-cycle pulse; invalid code, or valid while pending
booth_timeout  output  NUM_BOOTHS  1-cycle pulse; armed booth timed out
count_1, count_2, count_3  output  WIDTH each  per-candidate tallies
total_votes  output  WIDTH  sum of accepted votes (saturating)
overflow  output  1  sticky; any counter saturated
session_state  output  2  00 CLOSED, 01 OPEN, 10 DRAINING

Behaviour:
- Reset (async, rst low) clears everything to zero:
  - session FSM goes to CLOSED.
  - All armed, pending and timeout registers, all counters and overflow clear.
  - Round-robin pointer resets to booth 0.
- Session FSM:
  - CLOSED -> OPEN when session_open = 1.
  - OPEN -> DRAINING when session_open = 0.
  - DRAINING -> CLOSED when no booth is pending.
  - DRAINING -> OPEN if session_open returns to 1 before draining completes.
- Entering DRAINING clears all armed bits. Pending votes are kept and still granted.
- Arming:
  - booth_enable[i] sets armed[i] next cycle, only in OPEN and only if booth i is neither armed nor pending.
  - Otherwise booth_enable[i] is ignored.
  - booth_armed equals armed[i].
- Per-booth idle counter:
  - Loads 0 on arming and increments each cycle while armed.
  - At TIMEOUT-1 with no valid vote that cycle: armed[i] clears and booth_timeout[i] pulses next cycle.
  - A valid vote in the timeout cycle wins over the timeout.
- Vote capture:
  - Condition: armed[i] and booth_vote_valid[i] with sel != 00.
  - Next cycle: the code latches into pending[i], armed[i] clears.
  - sel == 00 while armed: booth_reject[i] pulses next cycle, booth stays armed, idle counter is not reset.
  - booth_vote_valid while neither armed nor pending: silently ignored.
  - booth_vote_valid while pending: booth_reject[i] pulses.
- Arbitration:
  - Each cycle, among the pending booths, grant the first one at or after the RR pointer (wrapping).
  - On the edge ending that cycle:
    - the matching count_k and total_votes increment;
    - pending[i] clears;
    - booth_ack[i] pulses for one cycle;
    - the pointer moves to i+1 mod NUM_BOOTHS.
  - Latency: valid sampled in cycle T -> pending in T+1 -> earliest ack in cycle T+2.
  - At most one grant per cycle. A booth waits at most NUM_BOOTHS-1 grant cycles.
- Arithmetic:
  - Counters saturate at 2^WIDTH-1.
  - An increment attempted at the maximum holds the value, sets overflow, and is still acked.
  - total_votes saturates independently.
- clear_counts:
  - In CLOSED: zeros count_1/2/3, total_votes and overflow next cycle.
  - In OPEN or DRAINING: ignored.
- Simultaneous events:
  - A booth granted in the same cycle a new vote for it is captured: not possible, because pending blocks capture.
  - enable + valid for the same booth in the same cycle: valid is ignored, since the booth is not yet armed.
- Reset mid-operation drops pending votes without ack.
- Outputs are registered. The ack, reject and timeout pulses are never concurrent on one booth.

Test Plan:
- Reset, session_open=1, enable booth0, booth0 valid sel=01 at cycle T -> booth_ack[0] high in T+2, count_1=1, total_votes=1.
- All 3 booths armed, all vote in the same cycle (sel 01, 10, 11), pointer=0 -> acks on booths 0, 1, 2 in consecutive cycles; counts 1/1/1, total 3.
- Armed booth1 sends sel=00 -> booth_reject[1] pulse, still armed. Then sel=10 -> ack, count_2=1.
- TIMEOUT=4, arm booth2, no vote -> booth_timeout[2] pulses at cycle 5 after arming, booth_armed[2]=0; a later valid is ignored.
- WIDTH=3, 8 votes for candidate 3 -> count_3=7, overflow=1, 8 acks.
- Two pending votes, drop session_open -> DRAINING, both acked, then CLOSED. clear_counts -> all counts 0. clear_counts during OPEN -> no change.
